// File: rtl/game_pkg.sv
// Shared game definitions: top-level game-state encodings, the round_timer
// FSM encoding, default round timing and a small BCD helper.
package game_pkg;

    // Top-level game flow, owned by the game state controller.
    typedef enum logic [1:0] {
        GS_MENU      = 2'd0,
        GS_COUNTDOWN = 2'd1,
        GS_GAMEPLAY  = 2'd2,
        GS_GAME_OVER = 2'd3
    } game_state_t;

    // round_timer FSM.
    typedef enum logic [1:0] {
        RT_LOADED  = 2'd0,
        RT_RUNNING = 2'd1,
        RT_PAUSED  = 2'd2,
        RT_DONE    = 2'd3
    } rt_state_t;

    // Two-digit BCD value as shown on the HUD.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam int DEF_TICKS_PER_SEC = 60;
    localparam int DEF_ROUND_SECONDS = 99;
    localparam int DEF_WARN_SECONDS  = 10;

    // Binary 0..99 to two BCD digits; used to build constant reload values.
    function automatic bcd2_t to_bcd(input int value);
        bcd2_t result;
        result.tens = 4'(value / 10);
        result.ones = 4'(value % 10);
        return result;
    endfunction

endpackage

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD down counter with load, decrement enable and zero flag.
// Load has priority over decrement; the count stops at 00.
module bcd_down_counter2
    import game_pkg::*;
(
    input  logic       clk_game,
    input  logic       reset,
    input  logic       load,
    input  bcd2_t      load_value,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       zero
);

    bcd2_t cnt;

    // Digit register: reset/load reload, otherwise decrement with ones borrow.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples values from before the edge regardless of block order.
    always_ff @(posedge clk_game) begin
        if (reset || load) begin
            cnt <= load_value;
        end else if (dec && !zero) begin
            if (cnt.ones == 4'd0) begin
                cnt.ones <= 4'd9;
                cnt.tens <= cnt.tens - 4'd1;
            end else begin
                cnt.ones <= cnt.ones - 4'd1;
            end
        end
    end

    assign tens = cnt.tens;
    assign ones = cnt.ones;
    assign zero = (cnt.tens == 4'd0) && (cnt.ones == 4'd0);

endmodule

// File: rtl/round_timer.sv
// Round clock and round-end arbiter. Prescales clk_game into seconds, counts
// the round down in BCD, and ends the round on expiry or knockout, latching
// the winner from the health values sampled on that edge.
module round_timer
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int ROUND_SECONDS = DEF_ROUND_SECONDS,
    parameter int WARN_SECONDS  = DEF_WARN_SECONDS
) (
    input  logic       clk_game,
    input  logic       reset,
    input  logic       timer_reset,
    input  logic       timer_enable,
    input  logic [7:0] p1_health,
    input  logic [7:0] p2_health,
    output logic [3:0] seconds_tens,
    output logic [3:0] seconds_ones,
    output logic       tick_sec,
    output logic       warning,
    output logic       warning_blink,
    output logic       game_over_condition,
    output logic       winner_p1,
    output logic       winner_p2
);

    localparam int               SUB_W      = $clog2(TICKS_PER_SEC);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SUB_W-1:0] SUB_HALF   = SUB_W'(TICKS_PER_SEC / 2);
    localparam bcd2_t            ROUND_BCD  = to_bcd(ROUND_SECONDS);
    localparam logic [6:0]       WARN_LIMIT = 7'(WARN_SECONDS);

    rt_state_t        state, state_next;
    logic [SUB_W-1:0] sub_cnt, sub_next;
    logic             dec;
    logic             tick_next;
    logic             win_p1_next, win_p2_next;
    logic             cnt_zero;
    logic             ko;
    logic             last_sec;
    logic [6:0]       remaining;

    bcd_down_counter2 u_digits (
        .clk_game   (clk_game),
        .reset      (reset),
        .load       (timer_reset),
        .load_value (ROUND_BCD),
        .dec        (dec),
        .tens       (seconds_tens),
        .ones       (seconds_ones),
        .zero       (cnt_zero)
    );

    assign ko        = (p1_health == 8'd0) || (p2_health == 8'd0);
    assign last_sec  = (seconds_tens == 4'd0) && (seconds_ones == 4'd1);
    assign remaining = {3'b000, seconds_tens} * 7'd10 + {3'b000, seconds_ones};

    // State register plus prescaler, second pulse and latched winners.
    always_ff @(posedge clk_game) begin
        if (reset) begin
            state     <= RT_LOADED;
            sub_cnt   <= '0;
            tick_sec  <= 1'b0;
            winner_p1 <= 1'b0;
            winner_p2 <= 1'b0;
        end else begin
            state     <= state_next;
            sub_cnt   <= sub_next;
            tick_sec  <= tick_next;
            winner_p1 <= win_p1_next;
            winner_p2 <= win_p2_next;
        end
    end

    // Next-state: reload > KO > second decrement; DONE holds everything.
    // NOTE: every signal gets a hold/idle default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        sub_next    = sub_cnt;
        dec         = 1'b0;
        tick_next   = 1'b0;
        win_p1_next = winner_p1;
        win_p2_next = winner_p2;
        if (timer_reset) begin
            state_next  = RT_LOADED;
            sub_next    = '0;
            win_p1_next = 1'b0;
            win_p2_next = 1'b0;
        end else if (state != RT_DONE) begin
            if (timer_enable) begin
                if (ko) begin
                    state_next  = RT_DONE;
                    win_p1_next = p1_health > p2_health;
                    win_p2_next = p2_health > p1_health;
                end else begin
                    state_next = RT_RUNNING;
                    if (sub_cnt == SUB_LAST) begin
                        sub_next  = '0;
                        dec       = 1'b1;
                        tick_next = 1'b1;
                        if (last_sec) begin
                            state_next  = RT_DONE;
                            win_p1_next = p1_health > p2_health;
                            win_p2_next = p2_health > p1_health;
                        end
                    end else begin
                        sub_next = sub_cnt + 1'b1;
                    end
                end
            end else if (state == RT_RUNNING) begin
                state_next = RT_PAUSED;
            end
        end
    end

    // Status outputs decoded from registered state, digits and prescaler only.
    always_comb begin
        game_over_condition = (state == RT_DONE);
        warning             = ((state == RT_RUNNING) || (state == RT_PAUSED)) &&
                              !cnt_zero && (remaining <= WARN_LIMIT);
        warning_blink       = warning && (sub_cnt < SUB_HALF);
    end

endmodule

// File: doc/round_timer.md
# round_timer

Round clock and round-end arbiter for gameplay. Consumes the game state controller's `timer_enable`/`timer_reset` and both players' health. Counts the round down in whole seconds as two BCD digits for the HUD. Drives `game_over_condition`, `winner_p1` and `winner_p2` back to the game state controller when time expires or a player is knocked out.

## Interface
- `TICKS_PER_SEC`, 60: `clk_game` cycles per displayed second; must be 2 or more.
- `ROUND_SECONDS`, 99: round length, 1..99.
- `WARN_SECONDS`, 10: low-time warning threshold; must be less than `ROUND_SECONDS`.

- `clk_game` in 1: 60 Hz game clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `timer_reset` in 1: reload the round; level, sampled each edge.
- `timer_enable` in 1: count while high.
- `p1_health` in 8: unsigned player 1 health.
- `p2_health` in 8: unsigned player 2 health.
- `seconds_tens` out 4: BCD tens digit of remaining time.
- `seconds_ones` out 4: BCD ones digit of remaining time.
- `tick_sec` out 1: one-cycle pulse on each second decrement.
- `warning` out 1: remaining time is at or below `WARN_SECONDS` and the round is not over.
- `warning_blink` out 1: `warning` gated by the first half of each second.
- `game_over_condition` out 1: round over; sticky.
- `winner_p1` out 1: valid while `game_over_condition` is high.
- `winner_p2` out 1: valid while `game_over_condition` is high.

## Operation
- FSM states:
  - LOADED: after reset or reload.
  - RUNNING: counting.
  - PAUSED: `timer_enable` low after running; prescaler and digits hold.
  - DONE: round over.
- Priority per edge: `reset` > `timer_reset` > KO > second decrement.
- `reset` or `timer_reset`:
  - State goes to LOADED, prescaler `sub_cnt` to 0.
  - Digits load `ROUND_SECONDS` (e.g. 9,9).
  - All other outputs go to 0.
- In LOADED, RUNNING or PAUSED with `timer_enable` high:
  - State goes to RUNNING.
  - `sub_cnt` increments modulo `TICKS_PER_SEC`.
  - On the wrap from `TICKS_PER_SEC`-1 to 0: digits decrement (ones 0 borrows: ones becomes 9, tens decrements) and `tick_sec` is high for that cycle.
- RUNNING with `timer_enable` low: go to PAUSED. PAUSED with `timer_enable` high resumes without losing sub-second progress.
- Expiry: a decrement that yields 00 enters DONE on the same edge.
- KO: in LOADED, RUNNING or PAUSED with `timer_enable` high, `p1_health`==0 or `p2_health`==0 enters DONE. A KO on the wrap cycle suppresses that decrement.
- On DONE entry, the winner is latched from the sampled health:
  - p1 > p2: `winner_p1`=1.
  - p2 > p1: `winner_p2`=1.
  - Equal, including both 0: draw, both winner outputs 0.
- DONE:
  - `game_over_condition`=1.
  - Digits, winners and `sub_cnt` frozen.
  - `timer_enable` ignored; exit only via `reset` or `timer_reset`.
- `warning` = (state is RUNNING or PAUSED) and remaining ≤ `WARN_SECONDS`. Remaining is compared as tens×10+ones.
- `warning_blink` = `warning` and `sub_cnt` < `TICKS_PER_SEC`/2.

## Timing
- All outputs are registered; no combinational input-to-output path.
- From reload, the first `tick_sec` occurs on exactly the `TICKS_PER_SEC`-th enabled edge. Default: 99 s requires 5940 enabled cycles.
- KO latency: health==0 sampled at edge N gives `game_over_condition` high after edge N.
- Expiry: `seconds_*`=0,0, `tick_sec`=1 and `game_over_condition`=1 all assert after the same edge. `tick_sec` deasserts the next cycle.
- `timer_reset` held high keeps the block in LOADED; counting starts on the first edge with `timer_reset`=0 and `timer_enable`=1.
- Reset mid-round gives full reload values after that edge, independent of state.

## Structure
- The shared package `game_pkg` holds:
  - Game-state encodings (MENU, COUNTDOWN, GAMEPLAY, GAME_OVER).
  - The round_timer FSM state encoding.
  - Default `TICKS_PER_SEC`, `ROUND_SECONDS` and `WARN_SECONDS`.
- Sub-module `bcd_down_counter2` is natural.
  - Inputs: load, load value, decrement enable.
  - Outputs: two BCD digits and a zero flag.
- The prescaler, FSM and winner latch stay in `round_timer`.

## Test plan
All scenarios use `TICKS_PER_SEC`=4, `ROUND_SECONDS`=12, `WARN_SECONDS`=10.
- Free run:
  - Stimulus: enable held after reset, health 50/50.
  - `tick_sec` every 4 cycles; digits 1,2 → 1,1 → 1,0 → 0,9 (borrow correct).
  - After 48 enabled edges: 0,0, `game_over_condition`=1, draw.
- Pause:
  - Stimulus: enable low for 7 cycles after 2 enabled cycles.
  - Digits and `sub_cnt` held; first `tick_sec` arrives after 2 more enabled cycles.
- KO:
  - Stimulus: `p2_health`=0 at 1,1 with `sub_cnt`=3.
  - `game_over_condition`=1 and `winner_p1`=1 next cycle; digits stay 1,1; no `tick_sec`.
- Timeout winner:
  - Stimulus: health 30/70 at expiry.
  - `winner_p2`=1; both-zero KO gives a draw.
- DONE hold and reload:
  - Stimulus: toggle enable and health in DONE.
  - No change; `timer_reset` pulse gives 1,2, all flags 0, state LOADED.
- Warning:
  - At 1,0 `warning`=1; `warning_blink` high for 2 of every 4 cycles.
  - In DONE, `warning`=0.
  - `reset` asserted mid-count reloads 1,2 after that edge.
